// File: rtl/decode_stage_pipelined.sv
// MIPS decode stage: register file with write-through, control decode,
// early branch resolution with Memory forwarding, and a flushable ID/EX register.
module decode_stage_pipelined #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter bit          BNE_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      InstrD,
    input  logic [WIDTH-1:0] PCPlus4D,
    input  logic             RegWriteW,
    input  logic [4:0]       WriteRegW,
    input  logic [WIDTH-1:0] ResultW,
    input  logic [WIDTH-1:0] ALUOutM,
    input  logic             ForwardAD,
    input  logic             ForwardBD,
    input  logic             FlushE,
    output logic [1:0]       PCSrcD,
    output logic [WIDTH-1:0] PCBranchD,
    output logic [WIDTH-1:0] PCJumpD,
    output logic             BranchD,
    output logic [4:0]       RsD,
    output logic [4:0]       RtD,
    output logic             RegWriteE,
    output logic             MemtoRegE,
    output logic             MemWriteE,
    output logic             ALUSrcE,
    output logic             RegDstE,
    output logic [2:0]       ALUControlE,
    output logic [WIDTH-1:0] RD1E,
    output logic [WIDTH-1:0] RD2E,
    output logic [WIDTH-1:0] SignImmE,
    output logic [4:0]       RsE,
    output logic [4:0]       RtE,
    output logic [4:0]       RdE
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             alu_src;
        logic             reg_dst;
        logic [2:0]       alu_control;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] sign_imm;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
    } idex_t;

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             reg_write_c, mem_to_reg_c, mem_write_c, alu_src_c, reg_dst_c;
    logic [2:0]       alu_control_c;
    logic             is_beq, is_bne, jump_c;
    logic             r_ok;
    logic [2:0]       r_alu;
    logic             wr_en;
    logic [WIDTH-1:0] rf_q [1:DEPTH-1];
    logic [WIDTH-1:0] rf_d [1:DEPTH-1];
    logic [WIDTH-1:0] rd1_c, rd2_c, cmp_a, cmp_b, sign_imm;
    logic             taken;
    logic [27:0]      jump_low;
    idex_t            idex_d, idex_q;

    assign opcode = InstrD[31:26];
    assign funct  = InstrD[5:0];
    assign RsD    = InstrD[25:21];
    assign RtD    = InstrD[20:16];

    // Control decoder; anything unrecognised decodes as a NOP
    always_comb begin
        reg_write_c   = 1'b0;
        mem_to_reg_c  = 1'b0;
        mem_write_c   = 1'b0;
        alu_src_c     = 1'b0;
        reg_dst_c     = 1'b0;
        alu_control_c = 3'b000;
        is_beq        = 1'b0;
        is_bne        = 1'b0;
        jump_c        = 1'b0;
        r_ok          = 1'b1;
        r_alu         = 3'b000;
        case (funct)
            6'b100000: r_alu = 3'b010;
            6'b100010: r_alu = 3'b110;
            6'b100100: r_alu = 3'b000;
            6'b100101: r_alu = 3'b001;
            6'b101010: r_alu = 3'b111;
            default:   r_ok  = 1'b0;
        endcase
        case (opcode)
            OP_RTYPE: begin
                if (r_ok) begin
                    reg_write_c   = 1'b1;
                    reg_dst_c     = 1'b1;
                    alu_control_c = r_alu;
                end
            end
            OP_LW: begin
                reg_write_c   = 1'b1;
                mem_to_reg_c  = 1'b1;
                alu_src_c     = 1'b1;
                alu_control_c = 3'b010;
            end
            OP_SW: begin
                mem_write_c   = 1'b1;
                alu_src_c     = 1'b1;
                alu_control_c = 3'b010;
            end
            OP_ADDI: begin
                reg_write_c   = 1'b1;
                alu_src_c     = 1'b1;
                alu_control_c = 3'b010;
            end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = BNE_EN;
            OP_J:    jump_c = 1'b1;
            default: ;
        endcase
    end

    // Register 0 and indices at or beyond DEPTH are never written
    assign wr_en = RegWriteW && (WriteRegW != 5'd0) && (32'(WriteRegW) < DEPTH);

    always_comb begin
        for (int unsigned i = 1; i < DEPTH; i++) begin
            rf_d[i] = rf_q[i];
            if (wr_en && (WriteRegW == 5'(i))) rf_d[i] = ResultW;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 1; i < DEPTH; i++) rf_q[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) rf_q[i] <= rf_d[i];
        end
    end

    // Combinational reads with same-cycle writeback bypass
    always_comb begin
        rd1_c = '0;
        rd2_c = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (RsD == 5'(i)) rd1_c = rf_q[i];
            if (RtD == 5'(i)) rd2_c = rf_q[i];
        end
        if (wr_en && (WriteRegW == RsD)) rd1_c = ResultW;
        if (wr_en && (WriteRegW == RtD)) rd2_c = ResultW;
    end

    assign cmp_a   = ForwardAD ? ALUOutM : rd1_c;
    assign cmp_b   = ForwardBD ? ALUOutM : rd2_c;
    assign taken   = (is_beq && (cmp_a == cmp_b)) || (is_bne && (cmp_a != cmp_b));
    assign BranchD = is_beq || is_bne;

    always_comb begin
        PCSrcD = 2'b00;
        if (jump_c)     PCSrcD = 2'b10;
        else if (taken) PCSrcD = 2'b01;
    end

    assign sign_imm  = WIDTH'($signed(InstrD[15:0]));
    assign PCBranchD = PCPlus4D + (sign_imm << 2);
    assign jump_low  = {InstrD[25:0], 2'b00};

    if (WIDTH > 28) begin : g_jump_wide
        assign PCJumpD = {PCPlus4D[WIDTH-1:28], jump_low};
    end else if (WIDTH == 28) begin : g_jump_exact
        assign PCJumpD = jump_low;
    end else begin : g_jump_narrow
        assign PCJumpD = jump_low[WIDTH-1:0];
    end

    // ID/EX capture; a flush loads an all-zero bubble
    always_comb begin
        idex_d = '0;
        if (!FlushE) begin
            idex_d.reg_write   = reg_write_c;
            idex_d.mem_to_reg  = mem_to_reg_c;
            idex_d.mem_write   = mem_write_c;
            idex_d.alu_src     = alu_src_c;
            idex_d.reg_dst     = reg_dst_c;
            idex_d.alu_control = alu_control_c;
            idex_d.rd1         = rd1_c;
            idex_d.rd2         = rd2_c;
            idex_d.sign_imm    = sign_imm;
            idex_d.rs          = InstrD[25:21];
            idex_d.rt          = InstrD[20:16];
            idex_d.rd          = InstrD[15:11];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemtoRegE   = idex_q.mem_to_reg;
    assign MemWriteE   = idex_q.mem_write;
    assign ALUSrcE     = idex_q.alu_src;
    assign RegDstE     = idex_q.reg_dst;
    assign ALUControlE = idex_q.alu_control;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign SignImmE    = idex_q.sign_imm;
    assign RsE         = idex_q.rs;
    assign RtE         = idex_q.rt;
    assign RdE         = idex_q.rd;

endmodule

// File: doc/decode_stage_pipelined.md
# decode_stage_pipelined

Parametrised decode stage for the pipelined MIPS core. It sits between the IF/ID and EX stages and contains:
- the architected register file, with write-through bypass;
- the control decoder;
- early branch resolution in Decode, with forwarding from Memory;
- the ID/EX pipeline register, which supports flush.

Beyond the previous stage, it adds generic data width and register depth, BNE support, same-cycle writeback bypass, and an owned, flushable ID/EX register.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be ≥ 16.
- DEPTH, 32, number of architected registers; must be ≤ 32. Register index 0 is hardwired to zero.
- BNE_EN, 1, when 1, opcode 000101 is decoded as BNE; when 0, it is undefined.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- InstrD  in  32  instruction from IF/ID.
- PCPlus4D  in  WIDTH  PC+4 from IF/ID.
- RegWriteW  in  1  writeback enable.
- WriteRegW  in  5  writeback destination register.
- ResultW  in  WIDTH  writeback data.
- ALUOutM  in  WIDTH  Memory-stage ALU result, used for branch forwarding.
- ForwardAD, ForwardBD  in  1 each  select ALUOutM for the comparator operands.
- FlushE  in  1  load a bubble into ID/EX.
- PCSrcD  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target.
- PCBranchD  out  WIDTH  PCPlus4D + (SignImm << 2).
- PCJumpD  out  WIDTH  {PCPlus4D[WIDTH-1:28], InstrD[25:0], 2'b00}.
- BranchD  out  1  BEQ or BNE decoded; used by the hazard unit.
- RsD, RtD  out  5 each  InstrD[25:21] and InstrD[20:16].
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  registered control.
- ALUControlE  out  3  registered ALU operation.
- RD1E, RD2E, SignImmE  out  WIDTH each  registered operands.
- RsE, RtE, RdE  out  5 each  registered register indices.

## Operation
Control decode (combinational):
- R-type (000000), funct mapping: 100000→010 (add), 100010→110 (sub), 100100→000 (and), 100101→001 (or), 101010→111 (slt). Sets RegWrite=1, RegDst=1.
- lw (100011): RegWrite, MemtoReg, ALUSrc, ALUControl 010.
- sw (101011): MemWrite, ALUSrc, ALUControl 010.
- addi (001000): RegWrite, ALUSrc, ALUControl 010.
- beq (000100): Branch. bne (000101, when BNE_EN=1): Branch.
- j (000010): Jump.
- Unknown opcode or funct: all controls 0. This is a NOP; it must not lock up.

Register file:
- DEPTH × WIDTH registers, written on the CLK rising edge when RegWriteW=1 and 0 < WriteRegW < DEPTH.
- Writes to register 0 or to an index ≥ DEPTH are ignored. Reads of those indices return 0.
- Reads are combinational. If RegWriteW=1, WriteRegW equals the read address, and that address is nonzero and < DEPTH, the read returns ResultW (same-cycle write-through).

Branch resolution:
- CmpA = ForwardAD ? ALUOutM : RD1. CmpB = ForwardBD ? ALUOutM : RD2.
- Taken = (BEQ & CmpA==CmpB) | (BNE & CmpA!=CmpB).
- PCSrcD = 10 if Jump, else 01 if Taken, else 00. Jump has priority.

Arithmetic:
- SignImm = InstrD[15:0] sign-extended to WIDTH.
- PCBranchD uses modulo-2^WIDTH addition; wrap-around is not flagged.

ID/EX register:
- Updates every rising edge with the decoded values. RD1E/RD2E take the bypassed register-file reads, not the forwarded comparator operands.

## Timing
- RST asserted: all E outputs and all register-file entries go to 0 immediately, without waiting for CLK.
- RST asserted mid-write: the write is lost.
- RST released: the first capture happens on the next rising edge.
- D outputs are combinational from the inputs, with zero latency.
- E outputs have a latency of one cycle from InstrD.
- FlushE=1 at an edge: every E output loads 0, which is a bubble. FlushE overrides any decoded value.
- A register-file write and an ID/EX capture can occur on the same edge. The E stage then captures the new value through the bypass.
- The same edge may see RegWriteW with WriteRegW=0 while FlushE=1: register 0 stays 0, and the E outputs go to 0.

## Test plan
- Reset with RST=1 mid-cycle while RegWriteW=1 → all E outputs 0 immediately. After release, a read of any register returns 0.
- Write 0x0000_1234 to r5, then decode `add r3,r5,r0` in the same cycle → RD1E=0x1234 and ALUControlE=010 one edge later, via the bypass.
- `beq r1,r2` with r1=r2=7 → PCSrcD=01. Same instruction with ForwardAD=1 and ALUOutM=8 → PCSrcD=00. `bne` under the same forwarding → 01. With BNE_EN=0, `bne` → 00 and BranchD=0.
- `j 0x0000040` with PCPlus4D=0x1000_0004 → PCSrcD=10, PCJumpD=0x1000_0100. Jump wins when Branch is also forced.
- `lw` decoded with FlushE=1 → all E outputs 0 on the edge. The next cycle, without flush, shows MemtoRegE=1.
- Write to r0 and to r31 with DEPTH=16 → both read back 0. `addi` with imm 0xFFFC and WIDTH=32 → SignImmE=0xFFFF_FFFC, and PCBranchD=PCPlus4D−16.
